load_wb_unit: RTL and testbench

Load-completion and writeback stage that sits directly upstream of register_file and drives its rd_addr/wr_data/wr_en write port. It accepts one RV32I load (LB/LH/LW/LBU/LHU) at a time and runs a word-aligned data-memory transaction with a request/response handshake. It extracts and sign- or zero-extends the addressed byte or halfword, then writes the result back. It also merges single-cycle ALU writebacks onto the same port, and load results take priority.

---
 rtl/load_wb_unit.sv | 158 +++++++++++++++
 tb/tb_load_wb_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_wb_unit.sv
// Load-completion and writeback stage: runs one word-aligned memory read per RV32I load,
// extracts and extends the addressed byte or halfword, and merges ALU writebacks onto one register-file port.
module load_wb_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  input  logic [RA_W-1:0] req_rd,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            alu_wb_valid,
  output logic            alu_wb_ready,
  input  logic [RA_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic [RA_W-1:0] rd_addr,
  output logic [XLEN-1:0] wr_data,
  output logic            wr_en,
  output logic            load_fault,
  output logic            busy
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      lat_off;
  logic [2:0]      lat_funct3;
  logic [RA_W-1:0] lat_rd;

  logic            accept;
  logic            fault;
  logic            load_done;
  logic            alu_fire;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_result;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && !fault) state_nxt = S_REQ;
      S_REQ:  if (mem_ready) state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Combinational outputs and request decode
  always_comb begin
    req_ready    = 1'b0;
    busy         = 1'b1;
    alu_wb_ready = 1'b1;
    load_done    = 1'b0;
    fault        = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WAIT: begin
        load_done    = mem_rvalid;
        alu_wb_ready = !mem_rvalid;
      end
      default: ;
    endcase
    case (req_funct3)
      F3_LB, F3_LBU: fault = 1'b0;
      F3_LH, F3_LHU: fault = req_addr[0];
      F3_LW:         fault = (req_addr[1:0] != 2'b00);
      default:       fault = 1'b1;
    endcase
  end

  assign accept   = req_valid && req_ready;
  assign alu_fire = alu_wb_valid && alu_wb_ready;

  // Byte/halfword extraction from the latched offset
  always_comb begin
    case (lat_off)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      F3_LB:   load_result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_result = {{(XLEN-16){1'b0}}, half_sel};
      default: load_result = mem_rdata;
    endcase
  end

  // Latched request, memory port and writeback registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_off    <= 2'b00;
      lat_funct3 <= 3'b000;
      lat_rd     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      rd_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      load_fault <= 1'b0;
    end else begin
      load_fault <= accept && fault;
      wr_en      <= 1'b0;
      if (accept && !fault) begin
        lat_off    <= req_addr[1:0];
        lat_funct3 <= req_funct3;
        lat_rd     <= req_rd;
        mem_req    <= 1'b1;
        mem_addr   <= {req_addr[XLEN-1:2], 2'b00};
      end else if (state == S_REQ && mem_ready) begin
        mem_req <= 1'b0;
      end
      // Load results win the port; the ALU is stalled by alu_wb_ready that cycle
      if (load_done) begin
        if (lat_rd != '0) begin
          wr_en   <= 1'b1;
          rd_addr <= lat_rd;
          wr_data <= load_result;
        end
      end else if (alu_fire && alu_rd != '0) begin
        wr_en   <= 1'b1;
        rd_addr <= alu_rd;
        wr_data <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_load_wb_unit.sv
// Directed self-checking bench for load_wb_unit: reset, stalled LW, extension cases,
// faults, ALU/load collision, x0 writes and reset during an outstanding load.
module tb_load_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        alu_wb_valid;
  logic        alu_wb_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic [4:0]  rd_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        load_fault;
  logic        busy;

  int checks = 0;
  int errors = 0;

  load_wb_unit #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .rd_addr(rd_addr), .wr_data(wr_data), .wr_en(wr_en),
    .load_fault(load_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One load with an immediate handshake and rvalid the cycle after it
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] rdata);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    req_rd     = rd;
    tick();
    req_valid = 1'b0;
    chk("ld_mem_req", 32'(mem_req), 32'd1);
    chk("ld_mem_addr", mem_addr, {addr[31:2], 2'b00});
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
  endtask

  logic [31:0] ext_addr [5] = '{32'h200, 32'h200, 32'h201, 32'h202, 32'h202};
  logic [2:0]  ext_f3   [5] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101};
  logic [31:0] ext_exp  [5] = '{32'hFFFFFF81, 32'h00000081, 32'h0000007F, 32'hFFFF80F1, 32'h000080F1};
  logic [31:0] flt_addr [3] = '{32'h102, 32'h101, 32'h100};
  logic [2:0]  flt_f3   [3] = '{3'b010, 3'b001, 3'b011};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    alu_wb_valid = 1'b0; alu_rd = '0; alu_data = '0;

    // Reset with a stray rvalid present
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_fault", 32'(load_fault), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wr_en", 32'(wr_en), 32'd0);

    // LW 0x100 -> x5 with two stall cycles on mem_ready
    req_valid = 1'b1; req_addr = 32'h100; req_funct3 = 3'b010; req_rd = 5'd5;
    tick();
    req_valid = 1'b0;
    chk("lw_mem_req", 32'(mem_req), 32'd1);
    chk("lw_busy", 32'(busy), 32'd1);
    chk("lw_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lw_stall_req", 32'(mem_req), 32'd1);
      chk("lw_stall_addr", mem_addr, 32'h100);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("lw_req_drop", 32'(mem_req), 32'd0);
    chk("lw_wait_busy", 32'(busy), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_alu_ready_lo", 32'(alu_wb_ready), 32'd0);
    chk("lw_no_early_wr", 32'(wr_en), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    chk("lw_wr_en", 32'(wr_en), 32'd1);
    chk("lw_rd_addr", 32'(rd_addr), 32'd5);
    chk("lw_wr_data", wr_data, 32'hDEADBEEF);
    chk("lw_idle", 32'(req_ready), 32'd1);
    tick();
    chk("lw_wr_pulse", 32'(wr_en), 32'd0);
    chk("lw_rd_hold", 32'(rd_addr), 32'd5);

    // Byte/halfword extraction from 0x80F17F81
    for (int i = 0; i < 5; i++) begin
      do_load(ext_addr[i], ext_f3[i], 5'd9, 32'h80F17F81);
      chk("ext_wr_en", 32'(wr_en), 32'd1);
      chk("ext_wr_data", wr_data, ext_exp[i]);
    end
    tick();

    // Faulting requests: one-cycle pulse, no memory access, no write
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = flt_addr[i]; req_funct3 = flt_f3[i]; req_rd = 5'd4;
      tick();
      req_valid = 1'b0;
      chk("flt_pulse", 32'(load_fault), 32'd1);
      chk("flt_mem_req", 32'(mem_req), 32'd0);
      chk("flt_busy", 32'(busy), 32'd0);
      tick();
      chk("flt_pulse_end", 32'(load_fault), 32'd0);
      chk("flt_mem_req2", 32'(mem_req), 32'd0);
      chk("flt_wr_en", 32'(wr_en), 32'd0);
    end

    // Collision: load to x7 and ALU to x10 in the same rvalid cycle
    req_valid = 1'b1; req_addr = 32'h300; req_funct3 = 3'b010; req_rd = 5'd7;
    tick();
    req_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    alu_wb_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hCAFEBABE;
    #1;
    chk("col_alu_ready", 32'(alu_wb_ready), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    chk("col_ld_wr_en", 32'(wr_en), 32'd1);
    chk("col_ld_rd", 32'(rd_addr), 32'd7);
    chk("col_ld_data", wr_data, 32'h11223344);
    chk("col_alu_ready2", 32'(alu_wb_ready), 32'd1);
    tick();
    alu_wb_valid = 1'b0;
    chk("col_alu_wr_en", 32'(wr_en), 32'd1);
    chk("col_alu_rd", 32'(rd_addr), 32'd10);
    chk("col_alu_data", wr_data, 32'hCAFEBABE);
    tick();
    chk("col_pulse", 32'(wr_en), 32'd0);

    // ALU write to x0 is dropped
    alu_wb_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0BADF00D;
    tick();
    alu_wb_valid = 1'b0;
    chk("alu_x0_wr_en", 32'(wr_en), 32'd0);
    chk("alu_x0_data_hold", wr_data, 32'hCAFEBABE);

    // Load to x0 completes the handshake but never writes
    do_load(32'h400, 3'b010, 5'd0, 32'h00000055);
    chk("ld_x0_wr_en", 32'(wr_en), 32'd0);
    chk("ld_x0_rd_hold", 32'(rd_addr), 32'd10);
    chk("ld_x0_idle", 32'(busy), 32'd0);
    tick();

    // Reset during WAIT abandons the load; late rvalid is ignored
    req_valid = 1'b1; req_addr = 32'h500; req_funct3 = 3'b010; req_rd = 5'd3;
    tick();
    req_valid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h00000099;
    tick();
    mem_rvalid = 1'b0;
    chk("mid_late_rvalid", 32'(wr_en), 32'd0);
    do_load(32'h603, 3'b100, 5'd8, 32'hAB000000);
    chk("mid_new_wr_en", 32'(wr_en), 32'd1);
    chk("mid_new_rd", 32'(rd_addr), 32'd8);
    chk("mid_new_data", wr_data, 32'h000000AB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
